// File: rtl/carbon_mmio_regs.sv
// carbon_mmio_regs
//   Common MMIO register block that sits behind the system address decoder.
//   It provides four word registers inside the MMIO window:
//     0x00 SIGNATURE   (RO)  constant identification word
//     0x04 POWEROFF    (RW)  sticky power-off request plus 8-bit exit code
//     0x08 UART_TX     (WO)  pushes wdata[7:0] into the TX FIFO
//     0x0C UART_STATUS (RO)  [0]=empty, [1]=full, [15:8]=FIFO level
//   The request/response bus allows one outstanding transaction. The TX FIFO
//   drains to a byte-stream sink (sim console or UART PHY) via valid/ready.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_addr/write/wdata/wstrb request payload (full byte address)
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata/rsp_err          response payload (rdata is 0 on writes/errors)
//   tx_valid/tx_data/tx_ready  FIFO head byte towards the sink (show-ahead)
//   poweroff/poweroff_code     sticky power-off request and its exit code
module carbon_mmio_regs #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_F000,
    parameter logic [31:0] ADDR_MASK  = 32'hFFFF_FF00,
    parameter logic [31:0] SIGNATURE  = 32'h4342_4E31,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,

    output logic        poweroff,
    output logic [7:0]  poweroff_code
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [29:0] OFF_MASK = ~ADDR_MASK[31:2];

    typedef enum logic [2:0] {
        REG_SIG,
        REG_PWR,
        REG_TX,
        REG_STAT,
        REG_NONE
    } reg_sel_e;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        hit;
    logic [29:0] off_word;
    reg_sel_e    sel;

    assign hit      = (req_addr & ADDR_MASK) == BASE_ADDR;
    // Word offset inside the window; byte-lane bits [1:0] are ignored.
    assign off_word = req_addr[31:2] & OFF_MASK;

    always_comb begin
        sel = REG_NONE;
        if (hit) begin
            case (off_word)
                30'd0:   sel = REG_SIG;
                30'd1:   sel = REG_PWR;
                30'd2:   sel = REG_TX;
                30'd3:   sel = REG_STAT;
                default: sel = REG_NONE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             empty;
    logic             full;

    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic uart_push_req;
    logic tx_stall;
    logic accept;
    logic push;
    logic pop;

    assign uart_push_req = req_valid && req_write && (sel == REG_TX) && req_wstrb[0];
    // Stall uses only the registered level, so a pop in the same cycle
    // never frees a slot for a same-cycle push and tx_ready has no
    // combinational path to req_ready.
    assign tx_stall  = full && uart_push_req;
    assign req_ready = rst_n && !rsp_valid && !tx_stall;
    assign accept    = req_valid && req_ready;
    assign push      = accept && uart_push_req;
    assign pop       = !empty && tx_ready;

    assign tx_valid  = !empty;
    assign tx_data   = empty ? '0 : mem[rd_ptr];

    // ------------------------------------------------------------------
    // Read data / error for the request being accepted
    // ------------------------------------------------------------------
    logic [31:0] rd_next;
    logic        err_next;
    logic [7:0]  level_b;

    assign level_b = 8'(level);

    always_comb begin
        rd_next  = '0;
        err_next = 1'b0;
        case (sel)
            REG_SIG:  if (!req_write) rd_next = SIGNATURE;
            REG_PWR:  if (!req_write) rd_next = {23'b0, poweroff, poweroff_code};
            REG_TX:   rd_next = '0;
            REG_STAT: if (!req_write) rd_next = {16'b0, level_b, 6'b0, full, empty};
            default:  err_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_next;
            rsp_err   <= err_next;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Power-off register (sticky until reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poweroff      <= 1'b0;
            poweroff_code <= '0;
        end else if (accept && req_write && (sel == REG_PWR) && (req_wstrb != 4'b0000)) begin
            poweroff <= 1'b1;
            if (req_wstrb[0]) begin
                poweroff_code <= req_wdata[7:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO pointers and level
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; reset empties the FIFO through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_wdata[7:0];
        end
    end

    logic unused_bits;
    assign unused_bits = ^{req_addr[1:0], req_wdata[31:8]};

endmodule

// File: tb/tb_carbon_mmio_regs.sv
module tb_carbon_mmio_regs;

    localparam logic [31:0] SIG = 32'h4342_4E31;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic        poweroff;
    logic [7:0]  poweroff_code;

    // Second instance with x86 window parameters
    logic        x_req_valid, x_req_ready;
    logic [31:0] x_req_addr;
    logic        x_rsp_valid, x_rsp_err;
    logic [31:0] x_rsp_rdata;
    logic        x_tx_valid, x_poweroff;
    logic [7:0]  x_tx_data, x_poweroff_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    carbon_mmio_regs dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .poweroff(poweroff), .poweroff_code(poweroff_code)
    );

    carbon_mmio_regs #(
        .BASE_ADDR(32'h000F_0000),
        .ADDR_MASK(32'hFFFF_F000)
    ) dut86 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(x_req_valid), .req_ready(x_req_ready), .req_addr(x_req_addr),
        .req_write(1'b0), .req_wdata(32'h0), .req_wstrb(4'h0),
        .rsp_valid(x_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(x_rsp_rdata),
        .rsp_err(x_rsp_err), .tx_valid(x_tx_valid), .tx_data(x_tx_data),
        .tx_ready(1'b1), .poweroff(x_poweroff), .poweroff_code(x_poweroff_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus transaction; starts and ends 1 time unit after a rising edge.
    // hold = cycles to keep rsp_ready low while checking the response is stable.
    task automatic bus(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] ws, input int hold,
                       output logic [31:0] rd, output logic er);
        int n;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wd;
        req_wstrb = ws;
        req_valid = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 40) begin
            check("accept_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            rd = '0;
            er = 1'b1;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rsp_latency", {31'b0, rsp_valid}, 32'd1);
        check("ready_busy", {31'b0, req_ready}, 32'd0);
        rd = rsp_rdata;
        er = rsp_err;
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("rsp_hold_valid", {31'b0, rsp_valid}, 32'd1);
            check("rsp_hold_ready", {31'b0, req_ready}, 32'd0);
            check("rsp_hold_rdata", rsp_rdata, rd);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_consumed", {31'b0, rsp_valid}, 32'd0);
        check("ready_back", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic pop_one();
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b0; tx_ready = 1'b0;
        x_req_valid = 1'b0; x_req_addr = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'b0, tx_data}, 32'd0);
        check("rst_poweroff", {23'b0, poweroff, poweroff_code}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Signature read, response held for two cycles
        bus(32'h0000_F000, 1'b0, 32'h0, 4'h0, 2, rd, er);
        check("sig_rdata", rd, SIG);
        check("sig_err", {31'b0, er}, 32'd0);
        bus(32'h0000_F000, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
        check("sig_wr_err", {31'b0, er}, 32'd0);
        check("sig_wr_rdata", rd, 32'd0);

        // Three bytes, status, then drain in order
        bus(32'h0000_F008, 1'b1, 32'h0000_0041, 4'h1, 0, rd, er);
        check("tx_wr_err", {31'b0, er}, 32'd0);
        check("tx_valid_first", {31'b0, tx_valid}, 32'd1);
        bus(32'h0000_F008, 1'b1, 32'h0000_0042, 4'h1, 0, rd, er);
        bus(32'h0000_F008, 1'b1, 32'h0000_0043, 4'h1, 0, rd, er);
        bus(32'h0000_F00C, 1'b0, 32'h0, 4'h0, 0, rd, er);
        check("status_3", rd, 32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            check("drain3_valid", {31'b0, tx_valid}, 32'd1);
            check("drain3_data", {24'b0, tx_data}, 32'h41 + i);
            pop_one();
        end
        check("drain3_empty", {31'b0, tx_valid}, 32'd0);

        // UART_TX write without byte lane 0 and UART_TX read: no push
        bus(32'h0000_F008, 1'b1, 32'h0000_0099, 4'hE, 0, rd, er);
        check("tx_nolane_err", {31'b0, er}, 32'd0);
        bus(32'h0000_F008, 1'b0, 32'h0, 4'h0, 0, rd, er);
        check("tx_rd_rdata", rd, 32'd0);
        check("tx_rd_err", {31'b0, er}, 32'd0);
        bus(32'h0000_F00C, 1'b0, 32'h0, 4'h0, 0, rd, er);
        check("status_empty", rd, 32'h0000_0001);

        // Fill to full, ninth write stalls until one pop
        for (int i = 0; i < 8; i++) begin
            bus(32'h0000_F008, 1'b1, 32'h50 + i, 4'h1, 0, rd, er);
        end
        req_addr = 32'h0000_F008; req_write = 1'b1; req_wdata = 32'h58; req_wstrb = 4'h1;
        req_valid = 1'b1;
        #1;
        check("full_stall0", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("full_stall1", {31'b0, req_ready}, 32'd0);
        check("full_no_rsp", {31'b0, rsp_valid}, 32'd0);
        check("full_head", {24'b0, tx_data}, 32'h50);
        pop_one();
        check("same_cycle_no_accept", {31'b0, rsp_valid}, 32'd0);
        check("ready_after_pop", {31'b0, req_ready}, 32'd1);
        bus(32'h0000_F008, 1'b1, 32'h58, 4'h1, 0, rd, er);
        bus(32'h0000_F00C, 1'b0, 32'h0, 4'h0, 0, rd, er);
        check("status_full", rd, 32'h0000_0802);
        // Non-UART requests still proceed while the FIFO is full
        bus(32'h0000_F000, 1'b0, 32'h0, 4'h0, 0, rd, er);
        check("full_sig", rd, SIG);
        for (int i = 0; i < 8; i++) begin
            check("drain8_data", {24'b0, tx_data}, 32'h51 + i);
            pop_one();
        end
        check("drain8_empty", {31'b0, tx_valid}, 32'd0);

        // Power-off
        bus(32'h0000_F004, 1'b1, 32'h0000_0107, 4'h1, 0, rd, er);
        check("pwr_flag", {23'b0, poweroff, poweroff_code}, 32'h0000_0107);
        bus(32'h0000_F004, 1'b0, 32'h0, 4'h0, 0, rd, er);
        check("pwr_read", rd, 32'h0000_0107);
        bus(32'h0000_F004, 1'b1, 32'h0000_0000, 4'h1, 0, rd, er);
        check("pwr_sticky", {23'b0, poweroff, poweroff_code}, 32'h0000_0100);
        bus(32'h0000_F004, 1'b1, 32'h0000_00AA, 4'h2, 0, rd, er);
        check("pwr_no_lane0", {23'b0, poweroff, poweroff_code}, 32'h0000_0100);

        // Decode errors with no side effects
        bus(32'h0000_F010, 1'b0, 32'h0, 4'h0, 0, rd, er);
        check("unmapped_err", {31'b0, er}, 32'd1);
        check("unmapped_rdata", rd, 32'd0);
        bus(32'h0000_E000, 1'b0, 32'h0, 4'h0, 0, rd, er);
        check("miss_err", {31'b0, er}, 32'd1);
        check("miss_rdata", rd, 32'd0);
        bus(32'h0000_E008, 1'b1, 32'h0000_0077, 4'h1, 0, rd, er);
        check("miss_wr_err", {31'b0, er}, 32'd1);
        bus(32'h0000_E004, 1'b1, 32'h0000_0033, 4'h1, 0, rd, er);
        check("miss_no_side", {22'b0, tx_valid, poweroff, poweroff_code}, 32'h0000_0100);
        bus(32'h0000_F00C, 1'b0, 32'h0, 4'h0, 0, rd, er);
        check("miss_status", rd, 32'h0000_0001);

        // x86 window
        x_req_addr = 32'h000F_0000;
        x_req_valid = 1'b1;
        #1;
        check("x86_ready", {31'b0, x_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        x_req_valid = 1'b0;
        check("x86_sig", x_rsp_rdata, SIG);
        check("x86_sig_err", {31'b0, x_rsp_valid, x_rsp_err}, 32'd2);
        @(posedge clk);
        #1;
        x_req_addr = 32'h0000_F000;
        x_req_valid = 1'b1;
        @(posedge clk);
        #1;
        x_req_valid = 1'b0;
        check("x86_miss", {x_rsp_rdata[29:0], x_rsp_valid, x_rsp_err}, 32'd3);

        // Reset mid-transaction
        for (int i = 0; i < 3; i++) begin
            bus(32'h0000_F008, 1'b1, 32'h61 + i, 4'h1, 0, rd, er);
        end
        req_addr = 32'h0000_F000; req_write = 1'b0; req_valid = 1'b1;
        #1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("pre_rst_rsp", {30'b0, rsp_valid, tx_valid}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("mid_rst_poweroff", {23'b0, poweroff, poweroff_code}, 32'd0);
        check("mid_rst_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus(32'h0000_F00C, 1'b0, 32'h0, 4'h0, 0, rd, er);
        check("post_rst_status", rd, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
